// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: condition codes, flag indices, branch FSM states
package cpu_pkg;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_GE = 3'b100;
  localparam logic [2:0] COND_CS = 3'b101;
  localparam logic [2:0] COND_CC = 3'b110;
  localparam logic [2:0] COND_NV = 3'b111;

  // Bit positions within the {N,Z,C,V} flag nibble
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } br_state_t;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational condition-code evaluator over {N,Z,C,V}
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [2:0] cond,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = flags[FLAG_Z];
      COND_NE: taken = ~flags[FLAG_Z];
      COND_LT: taken = flags[FLAG_N] ^ flags[FLAG_V];
      COND_GE: taken = ~(flags[FLAG_N] ^ flags[FLAG_V]);
      COND_CS: taken = flags[FLAG_C];
      COND_CC: taken = ~flags[FLAG_C];
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch resolution: flags register, target calc, PC load pulse, wrong-path flush
module branch_ctrl
  import cpu_pkg::*;
#(
  parameter int OFFSET_W     = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                br_valid,
  input  logic [2:0]          br_cond,
  input  logic                br_reg,
  input  logic [OFFSET_W-1:0] br_offset,
  input  logic [31:0]         cur_pc,
  input  logic [31:0]         reg_val,
  input  logic                flag_we,
  input  logic [3:0]          alu_flags,
  output logic                branch,
  output logic [31:0]         branch_adrx,
  output logic                flush,
  output logic [3:0]          flags,
  output logic [CNT_W-1:0]    taken_cnt
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  br_state_t   state;
  logic [2:0]  flush_cnt;
  logic [3:0]  eff_flags;
  logic        taken;
  logic [31:0] offset_sext;
  logic [31:0] target;

  // Forward the ALU's flags so a compare-and-branch pair resolves in one cycle
  assign eff_flags   = flag_we ? alu_flags : flags;
  assign offset_sext = {{(32-OFFSET_W){br_offset[OFFSET_W-1]}}, br_offset};
  assign target      = br_reg ? reg_val : (cur_pc + 32'd1 + offset_sext);

  cond_eval u_cond_eval (
    .flags (eff_flags),
    .cond  (br_cond),
    .taken (taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      flush_cnt   <= 3'd0;
      branch      <= 1'b0;
      branch_adrx <= 32'd0;
      flush       <= 1'b0;
      flags       <= 4'd0;
      taken_cnt   <= '0;
    end else begin
      if (flag_we) flags <= alu_flags;
      case (state)
        ST_IDLE: begin
          if (br_valid && taken) begin
            branch      <= 1'b1;
            branch_adrx <= target;
            flush       <= 1'b1;
            flush_cnt   <= FLUSH_INIT;
            if (taken_cnt != {CNT_W{1'b1}}) taken_cnt <= taken_cnt + CNT_W'(1);
            state       <= ST_FLUSH;
          end else begin
            branch <= 1'b0;
          end
        end
        // Instructions seen here are wrong-path, so br_valid is deliberately ignored
        ST_FLUSH: begin
          branch <= 1'b0;
          if (flush_cnt != 3'd0) begin
            flush_cnt <= flush_cnt - 3'd1;
          end else begin
            flush <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - directed self-checking bench for branch_ctrl
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic        br_reg;
  logic [15:0] br_offset;
  logic [31:0] cur_pc;
  logic [31:0] reg_val;
  logic        flag_we;
  logic [3:0]  alu_flags;
  logic        branch;
  logic [31:0] branch_adrx;
  logic        flush;
  logic [3:0]  flags;
  logic [15:0] taken_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.OFFSET_W(16), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .br_valid    (br_valid),
    .br_cond     (br_cond),
    .br_reg      (br_reg),
    .br_offset   (br_offset),
    .cur_pc      (cur_pc),
    .reg_val     (reg_val),
    .flag_we     (flag_we),
    .alu_flags   (alu_flags),
    .branch      (branch),
    .branch_adrx (branch_adrx),
    .flush       (flush),
    .flags       (flags),
    .taken_cnt   (taken_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    br_valid  = 1'b0;
    br_cond   = 3'b000;
    br_reg    = 1'b0;
    br_offset = 16'd0;
    cur_pc    = 32'd0;
    reg_val   = 32'd0;
    flag_we   = 1'b0;
    alu_flags = 4'd0;
  endtask

  task automatic issue(input logic [2:0] cond, input logic use_reg, input logic [15:0] off,
                       input logic [31:0] pc, input logic [31:0] rv);
    br_valid  = 1'b1;
    br_cond   = cond;
    br_reg    = use_reg;
    br_offset = off;
    cur_pc    = pc;
    reg_val   = rv;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    check("reset_branch", 32'(branch), 32'd0);
    check("reset_adrx", branch_adrx, 32'd0);
    check("reset_flush", 32'(flush), 32'd0);
    check("reset_flags", 32'(flags), 32'd0);
    check("reset_cnt", 32'(taken_cnt), 32'd0);
    rst = 1'b0;

    // AL branch: 0x10 + 1 + 5 = 0x16
    issue(3'b000, 1'b0, 16'd5, 32'h10, 32'd0);
    step();
    check("al_branch", 32'(branch), 32'd1);
    check("al_adrx", branch_adrx, 32'h16);
    check("al_flush1", 32'(flush), 32'd1);
    check("al_cnt", 32'(taken_cnt), 32'd1);
    idle_inputs();
    step();
    check("al_branch_once", 32'(branch), 32'd0);
    check("al_flush2", 32'(flush), 32'd1);
    step();
    check("al_flush_end", 32'(flush), 32'd0);
    check("al_adrx_hold", branch_adrx, 32'h16);

    // Forwarded Z with EQ: 0x20 + 1 - 4 = 0x1D
    issue(3'b001, 1'b0, 16'hFFFC, 32'h20, 32'd0);
    flag_we   = 1'b1;
    alu_flags = 4'b0100;
    step();
    check("fwd_branch", 32'(branch), 32'd1);
    check("fwd_adrx", branch_adrx, 32'h1D);
    check("fwd_flags", 32'(flags), 32'h4);
    check("fwd_cnt", 32'(taken_cnt), 32'd2);
    idle_inputs();
    step();
    step();

    // Not-taken paths from a clean reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    issue(3'b001, 1'b0, 16'd3, 32'h40, 32'd0);
    step();
    check("eq_nt_branch", 32'(branch), 32'd0);
    check("eq_nt_flush", 32'(flush), 32'd0);
    check("eq_nt_cnt", 32'(taken_cnt), 32'd0);
    issue(3'b111, 1'b0, 16'd3, 32'h40, 32'd0);
    flag_we   = 1'b1;
    alu_flags = 4'b1111;
    step();
    check("nv_branch", 32'(branch), 32'd0);
    check("nv_flush", 32'(flush), 32'd0);
    check("nv_cnt", 32'(taken_cnt), 32'd0);
    check("nv_flags", 32'(flags), 32'hF);
    idle_inputs();
    issue(3'b011, 1'b0, 16'd3, 32'h40, 32'd0);
    step();
    check("lt_nt_branch", 32'(branch), 32'd0);
    issue(3'b010, 1'b0, 16'd3, 32'h40, 32'd0);
    step();
    check("ne_nt_branch", 32'(branch), 32'd0);
    check("adrx_untouched", branch_adrx, 32'd0);

    // GE with N=V=1 is taken
    issue(3'b100, 1'b0, 16'd0, 32'h100, 32'd0);
    step();
    check("ge_branch", 32'(branch), 32'd1);
    check("ge_adrx", branch_adrx, 32'h101);
    idle_inputs();
    step();
    step();

    // PC-relative wrap-around
    issue(3'b000, 1'b0, 16'd0, 32'hFFFF_FFFF, 32'd0);
    step();
    check("wrap_branch", 32'(branch), 32'd1);
    check("wrap_adrx", branch_adrx, 32'h0);
    idle_inputs();
    step();
    step();

    // Indirect, then AL held through both flush cycles
    issue(3'b000, 1'b1, 16'd7, 32'h50, 32'h0000_ABCD);
    step();
    check("ind_branch", 32'(branch), 32'd1);
    check("ind_adrx", branch_adrx, 32'h0000_ABCD);
    reg_val = 32'h0000_1234;
    step();
    check("wp1_branch", 32'(branch), 32'd0);
    check("wp1_flush", 32'(flush), 32'd1);
    step();
    check("wp2_branch", 32'(branch), 32'd0);
    check("wp2_flush", 32'(flush), 32'd0);
    check("wp2_adrx", branch_adrx, 32'h0000_ABCD);
    step();
    check("post_flush_branch", 32'(branch), 32'd1);
    check("post_flush_adrx", branch_adrx, 32'h0000_1234);
    check("post_flush_cnt", 32'(taken_cnt), 32'd4);

    // Reset while in FLUSH, with competing inputs active
    rst       = 1'b1;
    flag_we   = 1'b1;
    alu_flags = 4'b1111;
    step();
    check("rmid_branch", 32'(branch), 32'd0);
    check("rmid_flush", 32'(flush), 32'd0);
    check("rmid_flags", 32'(flags), 32'd0);
    check("rmid_cnt", 32'(taken_cnt), 32'd0);
    rst = 1'b0;
    idle_inputs();
    issue(3'b000, 1'b0, 16'd1, 32'h200, 32'd0);
    step();
    check("rmid_idle_branch", 32'(branch), 32'd1);
    check("rmid_idle_adrx", branch_adrx, 32'h202);
    check("rmid_idle_cnt", 32'(taken_cnt), 32'd1);
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
